// File: rtl/bin_to_bcd_digits.sv
// Sequential binary-to-BCD converter (double dabble, one input bit per clock).
// Optional leading-zero flags are built when LEADING_ZERO_BLANK_EN is defined.
module bin_to_bcd_digits #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(IN_WIDTH - 1);

    generate
        if (IN_WIDTH < 1 || DIGITS < 1) begin : g_bad_param
            $error("bin_to_bcd_digits: IN_WIDTH and DIGITS must both be at least 1");
        end
    endgenerate

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    logic [IN_WIDTH-1:0]   shreg;
    logic [BW-1:0]         scratch;
    logic [CW-1:0]         cnt;
    logic                  sticky;

    logic [BW-1:0]         adj;
    logic [BW-1:0]         scratch_nxt;
    logic [IN_WIDTH-1:0]   shreg_nxt;
    logic                  top_bit;
    logic                  last;

    // Add-3 is a plain 4-bit add per nibble; a nibble >= 5 never exceeds 12,
    // so no carry ever crosses into the next digit.
    always_comb begin
        adj = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end else begin
                adj[4*i +: 4] = scratch[4*i +: 4];
            end
        end
    end

    always_comb begin
        top_bit     = adj[BW-1];
        scratch_nxt = {adj[BW-2:0], shreg[IN_WIDTH-1]};
        shreg_nxt   = shreg << 1;
        last        = (cnt == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            sticky   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd_out  <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg   <= bin_in;
                        scratch <= '0;
                        cnt     <= '0;
                        sticky  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= scratch_nxt;
                    shreg   <= shreg_nxt;
                    cnt     <= cnt + 1'b1;
                    sticky  <= sticky | top_bit;
                    if (last) begin
                        // Results publish on the final shift edge, so the
                        // done cycle is already idle and can accept a new start.
                        bcd_out  <= scratch_nxt;
                        overflow <= sticky | top_bit;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic              higher_zero;

    // Digit 0 is never flagged so that a value of zero still shows one "0".
    always_comb begin
        blank_nxt   = '0;
        higher_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            higher_zero  = higher_zero & (scratch_nxt[4*i +: 4] == 4'd0);
            blank_nxt[i] = higher_zero;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank <= '0;
        end else if (state == SHIFT && last) begin
            blank <= blank_nxt;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_digits.sv
// Self-checking bench for bin_to_bcd_digits: an 8-bit/3-digit instance and a
// 10-bit/3-digit instance, table vectors, random values and timing corners.
module tb_bin_to_bcd_digits;

    localparam int WA = 8;
    localparam int WB = 10;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic BZ = 1'b1;
`else
    localparam logic BZ = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;

    logic          start_a = 1'b0;
    logic [WA-1:0] bin_a = '0;
    logic          busy_a, done_a, ovf_a;
    logic [11:0]   bcd_a;
    logic [2:0]    blank_a;

    logic          start_b = 1'b0;
    logic [WB-1:0] bin_b = '0;
    logic          busy_b, done_b, ovf_b;
    logic [11:0]   bcd_b;
    logic [2:0]    blank_b;

    int checks   = 0;
    int failures = 0;

    bin_to_bcd_digits #(.IN_WIDTH(WA), .DIGITS(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .bin_in(bin_a),
        .busy(busy_a), .done(done_a), .bcd_out(bcd_a),
        .overflow(ovf_a), .blank(blank_a)
    );

    bin_to_bcd_digits #(.IN_WIDTH(WB), .DIGITS(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .bin_in(bin_b),
        .busy(busy_b), .done(done_b), .bcd_out(bcd_b),
        .overflow(ovf_b), .blank(blank_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned v;
        logic [11:0] bcd;
        logic        ovf;
        logic [2:0]  blank;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Decimal reference: digits by division, overflow by magnitude.
    function automatic void model(input int unsigned v, output logic [11:0] bcd,
                                  output logic ovf, output logic [2:0] bl);
        int unsigned r;
        int unsigned d0, d1, d2;
        ovf = (v > 999);
        r   = v % 1000;
        d0  = r % 10;
        d1  = (r / 10) % 10;
        d2  = r / 100;
        bcd = {d2[3:0], d1[3:0], d0[3:0]};
        bl[0] = 1'b0;
        bl[2] = BZ && (d2 == 0);
        bl[1] = BZ && (d2 == 0) && (d1 == 0);
    endfunction

    task automatic wait_done(input bit use_b, output int cyc, output bit ok, output bit busy_ok);
        cyc = 0;
        ok = 1'b0;
        busy_ok = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            cyc++;
            if (use_b ? done_b : done_a) begin
                ok = 1'b1;
                break;
            end
            if (!(use_b ? busy_b : busy_a)) busy_ok = 1'b0;
        end
    endtask

    task automatic run_conv(input bit use_b, input int unsigned v, input logic [11:0] eb,
                            input logic eo, input logic [2:0] ebl, input string tag);
        int cyc;
        bit ok, busy_ok;
        int lat;
        lat = use_b ? WB : WA;
        @(negedge clk);
        if (use_b) begin start_b = 1'b1; bin_b = WB'(v); end
        else       begin start_a = 1'b1; bin_a = WA'(v); end
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        bin_a = WA'($urandom);
        bin_b = WB'($urandom);
        chk({tag, "_busy_rise"}, use_b ? busy_b : busy_a, 1);
        wait_done(use_b, cyc, ok, busy_ok);
        chk({tag, "_done_seen"}, ok, 1);
        chk({tag, "_latency"}, cyc, lat);
        chk({tag, "_busy_held"}, busy_ok, 1);
        chk({tag, "_busy_done"}, use_b ? busy_b : busy_a, 0);
        chk({tag, "_bcd"}, use_b ? bcd_b : bcd_a, eb);
        chk({tag, "_ovf"}, use_b ? ovf_b : ovf_a, eo);
        chk({tag, "_blank"}, use_b ? blank_b : blank_a, ebl);
    endtask

    task automatic run_model(input bit use_b, input int unsigned v, input string tag);
        logic [11:0] eb;
        logic        eo;
        logic [2:0]  ebl;
        model(v, eb, eo, ebl);
        run_conv(use_b, v, eb, eo, ebl, tag);
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        vec_t tbl[10];
        int   cyc, dones, first_done, tot;
        bit   ok, busy_ok, busy_early;

        tbl[0] = '{0,   12'h000, 1'b0, {BZ, BZ, 1'b0}};
        tbl[1] = '{255, 12'h255, 1'b0, 3'b000};
        tbl[2] = '{100, 12'h100, 1'b0, 3'b000};
        tbl[3] = '{42,  12'h042, 1'b0, {BZ, 2'b00}};
        tbl[4] = '{7,   12'h007, 1'b0, {BZ, BZ, 1'b0}};
        tbl[5] = '{99,  12'h099, 1'b0, {BZ, 2'b00}};
        tbl[6] = '{1,   12'h001, 1'b0, {BZ, BZ, 1'b0}};
        tbl[7] = '{10,  12'h010, 1'b0, {BZ, 2'b00}};
        tbl[8] = '{200, 12'h200, 1'b0, 3'b000};
        tbl[9] = '{199, 12'h199, 1'b0, 3'b000};

        // Clock/reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_bcd", bcd_a, 0);
        chk("rst_ovf", ovf_a, 0);
        chk("rst_blank", blank_a, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            run_conv(1'b0, tbl[i].v, tbl[i].bcd, tbl[i].ovf, tbl[i].blank, $sformatf("tbl%0d", i));
        end

        for (int i = 0; i < 20; i++) begin
            run_model(1'b0, $urandom_range(0, 255), $sformatf("rnd_a%0d", i));
        end

        // Wide instance: overflow drops to the low three digits.
        run_conv(1'b1, 1023, 12'h023, 1'b1, {BZ, 2'b00}, "w1023");
        run_conv(1'b1, 999,  12'h999, 1'b0, 3'b000, "w999");
        run_conv(1'b1, 1000, 12'h000, 1'b1, {BZ, BZ, 1'b0}, "w1000");
        for (int i = 0; i < 10; i++) begin
            run_model(1'b1, $urandom_range(0, 1023), $sformatf("rnd_b%0d", i));
        end

        // Start during a conversion is ignored.
        @(negedge clk);
        start_a = 1'b1; bin_a = 8'd42;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start_a = 1'b1; bin_a = 8'd99;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        dones = 0; first_done = 0; tot = 3; busy_early = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            tot++;
            if (done_a) begin
                dones++;
                if (first_done == 0) begin
                    first_done = tot;
                    chk("mid_bcd", bcd_a, 12'h042);
                end
            end else if (first_done == 0 && !busy_a) begin
                busy_early = 1'b1;
            end
        end
        chk("mid_done_count", dones, 1);
        chk("mid_done_cycle", first_done, WA);
        chk("mid_busy_early", busy_early, 0);

        // Start held high: re-accepted in the done cycle.
        @(negedge clk);
        start_a = 1'b1; bin_a = 8'd7;
        wait_done(1'b0, cyc, ok, busy_ok);
        chk("b2b_first_seen", ok, 1);
        chk("b2b_first_bcd", bcd_a, 12'h007);
        bin_a = 8'd58;
        wait_done(1'b0, cyc, ok, busy_ok);
        start_a = 1'b0;
        chk("b2b_second_seen", ok, 1);
        chk("b2b_gap", cyc, WA + 1);
        chk("b2b_second_bcd", bcd_a, 12'h058);
        chk("b2b_busy_held", busy_ok, 1);

        // Reset in the middle of a conversion.
        @(negedge clk);
        start_a = 1'b1; bin_a = 8'd200;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy_a, 0);
        chk("arst_done", done_a, 0);
        chk("arst_bcd", bcd_a, 0);
        chk("arst_ovf", ovf_a, 0);
        chk("arst_blank", blank_a, 0);
        chk("arst_bcd_b", bcd_b, 0);
        chk("arst_ovf_b", ovf_b, 0);
        dones = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done_a) dones++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (WA + 2) begin
            @(posedge clk);
            #1;
            if (done_a) dones++;
        end
        chk("arst_no_done", dones, 0);
        chk("arst_idle", busy_a, 0);
        run_conv(1'b0, 13, 12'h013, 1'b0, {BZ, 2'b00}, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
